vga_plot_arb: RTL and testbench

VGA_PLOT_ARB -- requirements
Module: vga_plot_arb

---
 rtl/vga_plot_pkg.sv | 9 +
 rtl/vga_clear_sweep.sv | 44 ++++
 rtl/vga_plot_arb.sv | 144 ++++++++++++++
 tb/tb_vga_plot_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_plot_pkg.sv
// Shared constants and FSM state encoding for the VGA plot arbiter.
package vga_plot_pkg;
  localparam int unsigned N_DEF    = 8;
  localparam int unsigned ROWS_DEF = 120;
  localparam int unsigned COLS_DEF = 160;
  localparam int unsigned CW       = 3;

  typedef enum logic {ARB = 1'b0, CLEAR = 1'b1} plot_state_t;
endpackage

// File: rtl/vga_clear_sweep.sv
// Row-major x/y sweep counter used by the full-screen clear; x runs fastest.
module vga_clear_sweep
  import vga_plot_pkg::*;
#(
  parameter int unsigned n    = N_DEF,
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         i_start,
  input  logic         i_adv,
  output logic [n-1:0] o_x,
  output logic [n-2:0] o_y,
  output logic         o_done_c
);
  localparam int unsigned YW = n - 1;
  localparam logic [n-1:0]  X_LAST = n'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

  logic [n-1:0]  r_x;
  logic [YW-1:0] r_y;
  logic          w_x_last;

  assign w_x_last = (r_x == X_LAST);
  assign o_done_c = w_x_last && (r_y == Y_LAST);
  assign o_x      = r_x;
  assign o_y      = r_y;

  // Counters wrap at the screen edge, so they never leave the visible area.
  always_ff @(posedge CLOCK_50) begin
    if (reset || i_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (w_x_last) begin
        r_x <= '0;
        r_y <= o_done_c ? '0 : r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_plot_arb.sv
// Two-client round-robin pixel-write arbiter with an optional full-screen
// clear sweep, enabled by defining VGA_PLOT_ARB_CLEAR_EN.
module vga_plot_arb
  import vga_plot_pkg::*;
#(
  parameter int unsigned n    = N_DEF,
  parameter int unsigned ROWS = ROWS_DEF,
  parameter int unsigned COLS = COLS_DEF
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          req0,
  input  logic [n-1:0]  x0,
  input  logic [n-2:0]  y0,
  input  logic [CW-1:0] c0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [n-1:0]  x1,
  input  logic [n-2:0]  y1,
  input  logic [CW-1:0] c1,
  output logic          gnt1,
  input  logic          clear_start,
  input  logic [CW-1:0] clear_color,
  output logic          clear_busy,
  output logic [n-1:0]  VGA_X,
  output logic [n-2:0]  VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot
);
  logic          w_arb_en;
  logic          w_pick1;
  logic          r_last;
  logic          r_plot;
  logic [n-1:0]  r_vx;
  logic [n-2:0]  r_vy;
  logic [CW-1:0] r_vc;

  // r_last=1 means client 1 was granted most recently, so client 0 wins a tie.
  assign w_pick1 = req1 && (!req0 || !r_last);
  assign gnt0    = w_arb_en && req0 && !w_pick1;
  assign gnt1    = w_arb_en && w_pick1;

  assign plot      = r_plot;
  assign VGA_X     = r_vx;
  assign VGA_Y     = r_vy;
  assign VGA_COLOR = r_vc;

`ifdef VGA_PLOT_ARB_CLEAR_EN
  plot_state_t   r_state;
  logic [CW-1:0] r_clr_color;
  logic [n-1:0]  w_sx;
  logic [n-2:0]  w_sy;
  logic          w_sdone;
  logic          w_start;
  logic          w_adv;

  assign w_arb_en   = !reset && (r_state == ARB) && !clear_start;
  assign w_start    = (r_state == ARB) && clear_start;
  assign w_adv      = (r_state == CLEAR);
  assign clear_busy = (r_state == CLEAR);

  vga_clear_sweep #(.n(n), .ROWS(ROWS), .COLS(COLS)) u_sweep (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .i_start  (w_start),
    .i_adv    (w_adv),
    .o_x      (w_sx),
    .o_y      (w_sy),
    .o_done_c (w_sdone)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state     <= ARB;
      r_last      <= 1'b1;
      r_plot      <= 1'b0;
      r_vx        <= '0;
      r_vy        <= '0;
      r_vc        <= '0;
      r_clr_color <= '0;
    end else begin
      r_plot <= 1'b0;
      case (r_state)
        ARB: begin
          if (clear_start) begin
            r_state     <= CLEAR;
            r_clr_color <= clear_color;
          end else if (gnt0) begin
            r_plot <= 1'b1;
            r_vx   <= x0;
            r_vy   <= y0;
            r_vc   <= c0;
            r_last <= 1'b0;
          end else if (gnt1) begin
            r_plot <= 1'b1;
            r_vx   <= x1;
            r_vy   <= y1;
            r_vc   <= c1;
            r_last <= 1'b1;
          end
        end
        CLEAR: begin
          r_plot <= 1'b1;
          r_vx   <= w_sx;
          r_vy   <= w_sy;
          r_vc   <= r_clr_color;
          if (w_sdone) r_state <= ARB;
        end
      endcase
    end
  end
`else
  logic w_unused;

  assign w_unused   = ^{clear_start, clear_color, ROWS == 0, COLS == 0};
  assign w_arb_en   = !reset;
  assign clear_busy = 1'b0;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_last <= 1'b1;
      r_plot <= 1'b0;
      r_vx   <= '0;
      r_vy   <= '0;
      r_vc   <= '0;
    end else begin
      r_plot <= 1'b0;
      if (gnt0) begin
        r_plot <= 1'b1;
        r_vx   <= x0;
        r_vy   <= y0;
        r_vc   <= c0;
        r_last <= 1'b0;
      end else if (gnt1) begin
        r_plot <= 1'b1;
        r_vx   <= x1;
        r_vy   <= y1;
        r_vc   <= c1;
        r_last <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_vga_plot_arb.sv
// Scoreboard bench for vga_plot_arb: stimulus process predicts grants and
// pixel writes; a negedge monitor pops expected pixels and compares.
module tb_vga_plot_arb;
  import vga_plot_pkg::*;

  localparam int unsigned N    = N_DEF;
  localparam int unsigned YW   = N - 1;
  localparam int unsigned ROWS = ROWS_DEF;
  localparam int unsigned COLS = COLS_DEF;
  localparam int unsigned NPIX = ROWS * COLS;
`ifdef VGA_PLOT_ARB_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct {
    longint        due;
    logic [N-1:0]  x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
  } pix_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [N-1:0]  x0 = '0, x1 = '0;
  logic [YW-1:0] y0 = '0, y1 = '0;
  logic [CW-1:0] c0 = '0, c1 = '0;
  logic          gnt0, gnt1;
  logic          clear_start = 1'b0;
  logic [CW-1:0] clear_color = '0;
  logic          clear_busy;
  logic [N-1:0]  VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [CW-1:0] VGA_COLOR;
  logic          plot;

  vga_plot_arb dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .req0        (req0),
    .x0          (x0),
    .y0          (y0),
    .c0          (c0),
    .gnt0        (gnt0),
    .req1        (req1),
    .x1          (x1),
    .y1          (y1),
    .c1          (c1),
    .gnt1        (gnt1),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .VGA_X       (VGA_X),
    .VGA_Y       (VGA_Y),
    .VGA_COLOR   (VGA_COLOR),
    .plot        (plot)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  longint cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Staged stimulus for the next cycle
  logic          s_reset = 1'b1, s_req0 = 1'b0, s_req1 = 1'b0, s_clear_start = 1'b0;
  logic [N-1:0]  s_x0 = '0, s_x1 = '0;
  logic [YW-1:0] s_y0 = '0, s_y1 = '0;
  logic [CW-1:0] s_c0 = '0, s_c1 = '0, s_clear_color = '0;

  // Reference model state
  pix_t   q[$];
  bit     m_last = 1'b1;
  longint cs = -10, ce = -10;
  bit     eg0 = 1'b0, eg1 = 1'b0;
  longint mon_start = 64'h7fff_ffff_ffff_ffff;
  longint hold_rst_at = -1;

  task automatic chk(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0b want=%0b", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive staged inputs, predict, check grants/busy, queue pixels.
  task automatic step();
    longint k;
    bit busy_e;
    bit clr_acc;
    @(posedge CLOCK_50);
    #1;
    reset = s_reset; req0 = s_req0; req1 = s_req1;
    x0 = s_x0; y0 = s_y0; c0 = s_c0;
    x1 = s_x1; y1 = s_y1; c1 = s_c1;
    clear_start = s_clear_start; clear_color = s_clear_color;
    #1;
    k = cyc;
    busy_e = (k >= cs) && (k <= ce);
    eg0 = 1'b0; eg1 = 1'b0; clr_acc = 1'b0;
    if (!s_reset && !busy_e) begin
      if (CLR_EN && s_clear_start) clr_acc = 1'b1;
      else if (s_req0 && s_req1) begin
        // Tie goes to whichever client was not served last
        if (m_last) eg0 = 1'b1; else eg1 = 1'b1;
      end else begin
        eg0 = s_req0;
        eg1 = s_req1;
      end
    end
    chk("gnt0", gnt0, eg0);
    chk("gnt1", gnt1, eg1);
    if (k >= mon_start) chk("clear_busy", clear_busy, busy_e);
    if (eg0) begin
      q.push_back('{due: k + 1, x: s_x0, y: s_y0, c: s_c0});
      m_last = 1'b0;
    end
    if (eg1) begin
      q.push_back('{due: k + 1, x: s_x1, y: s_y1, c: s_c1});
      m_last = 1'b1;
    end
    if (clr_acc) begin
      cs = k + 1;
      ce = k + NPIX;
      for (int i = 0; i < int'(NPIX); i++)
        q.push_back('{due: k + 2 + i, x: N'(i % COLS), y: YW'(i / COLS), c: s_clear_color});
    end
    if (s_reset) begin
      q.delete();
      cs = -10; ce = -10;
      m_last = 1'b1;
      hold_rst_at = k + 1;
      if (mon_start > k + 1) mon_start = k + 1;
    end
  endtask

  // New random request for a client unless it is still waiting for a grant.
  task automatic pick_reqs(input int pct);
    if (!(s_req0 && !eg0)) begin
      s_req0 = ($urandom_range(0, 99) < pct);
      s_x0 = N'($urandom_range(0, COLS - 1));
      s_y0 = YW'($urandom_range(0, ROWS - 1));
      s_c0 = CW'($urandom);
    end
    if (!(s_req1 && !eg1)) begin
      s_req1 = ($urandom_range(0, 99) < pct);
      s_x1 = N'($urandom_range(0, COLS - 1));
      s_y1 = YW'($urandom_range(0, ROWS - 1));
      s_c1 = CW'($urandom);
    end
  endtask

  // Monitor: every cycle the output port must match the next due pixel or hold.
  logic [N-1:0]  h_x = '0;
  logic [YW-1:0] h_y = '0;
  logic [CW-1:0] h_c = '0;
  always @(negedge CLOCK_50) begin
    logic [N+YW+CW:0] act;
    logic [N+YW+CW:0] exp;
    if (cyc == hold_rst_at) begin
      h_x = '0; h_y = '0; h_c = '0;
    end
    if (cyc >= mon_start) begin
      act = {plot, VGA_X, VGA_Y, VGA_COLOR};
      if (q.size() > 0 && q[0].due == cyc) begin
        exp = {1'b1, q[0].x, q[0].y, q[0].c};
        h_x = q[0].x; h_y = q[0].y; h_c = q[0].c;
        void'(q.pop_front());
      end else begin
        exp = {1'b0, h_x, h_y, h_c};
      end
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL pixel cyc=%0d got plot=%0b x=%0d y=%0d c=%0d want plot=%0b x=%0d y=%0d c=%0d",
                 cyc, act[N+YW+CW], act[N+YW+CW-1 -: N], act[YW+CW-1 -: YW], act[CW-1:0],
                 exp[N+YW+CW], exp[N+YW+CW-1 -: N], exp[YW+CW-1 -: YW], exp[CW-1:0]);
      end
    end
  end

  initial begin
    int clr_len;
    clr_len = CLR_EN ? int'(NPIX) : 40;

    repeat (3) step();
    s_reset = 1'b0;
    step();

    // Single write from client 0
    s_req0 = 1'b1; s_x0 = N'(5); s_y0 = YW'(7); s_c0 = CW'(3);
    step();
    s_req0 = 1'b0;
    repeat (2) step();

    // Contention straight after reset: 0,1,0,1
    s_reset = 1'b1; step(); s_reset = 1'b0;
    s_req0 = 1'b1; s_x0 = N'(11); s_y0 = YW'(22); s_c0 = CW'(1);
    s_req1 = 1'b1; s_x1 = N'(33); s_y1 = YW'(44); s_c1 = CW'(6);
    repeat (4) step();
    s_req0 = 1'b0; s_req1 = 1'b0;
    step();

    for (int i = 0; i < 300; i++) begin
      pick_reqs(int'($urandom_range(20, 90)));
      step();
    end
    while (s_req0 || s_req1) begin
      if (eg0) s_req0 = 1'b0;
      if (eg1) s_req1 = 1'b0;
      if (s_req0 || s_req1) step();
    end

    // Full clear with client 1 waiting; stray clear_start pulses during the sweep
    s_req1 = 1'b1; s_x1 = N'(77); s_y1 = YW'(88); s_c1 = CW'(4);
    s_clear_start = 1'b1; s_clear_color = CW'(2);
    step();
    if (eg1) s_req1 = 1'b0;
    for (int i = 0; i < clr_len; i++) begin
      s_clear_start = ($urandom_range(0, 999) == 0);
      s_clear_color = CW'($urandom);
      step();
      if (eg1) s_req1 = 1'b0;
    end
    s_clear_start = 1'b0;
    repeat (4) begin
      step();
      if (eg1) s_req1 = 1'b0;
    end

    // Clear aborted by reset at pixel (40,3), then a dual request
    s_req0 = 1'b0; s_req1 = 1'b0;
    s_clear_start = 1'b1; s_clear_color = CW'(5);
    step();
    s_clear_start = 1'b0;
    repeat (3 * COLS + 40) step();
    s_reset = 1'b1; step(); s_reset = 1'b0;
    s_req0 = 1'b1; s_x0 = N'(COLS - 1); s_y0 = YW'(ROWS - 1); s_c0 = CW'(7);
    s_req1 = 1'b1; s_x1 = N'(0); s_y1 = YW'(0); s_c1 = CW'(0);
    repeat (2) step();
    s_req0 = 1'b0; s_req1 = 1'b0;
    step();

    for (int i = 0; i < 300; i++) begin
      pick_reqs(int'($urandom_range(10, 100)));
      step();
    end
    s_req0 = 1'b0; s_req1 = 1'b0;
    repeat (4) step();

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
